// File: rtl/sensor_pkg.sv
// Shared definitions for the delay-line sensor controller.
// Holds the controller state encoding, default window size and synchronizer depth.
// Pure package: no latency, no flow control.
package sensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MEAS  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WIN_LOG2_DEF = 8;
  localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/sensor_sync2.sv
// Purpose: 1-bit two-flop synchronizer bringing the sensor delay-line output into clk.
// Latency: SYNC_DEPTH (2) clk cycles from d to q.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module sensor_sync2
  import sensor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = sync_ff[SYNC_DEPTH-1];

endmodule

// File: rtl/sensor_ctrl.sv
// Purpose: counts high samples of the synchronized sensor delay-line output over a
//   2^WIN_LOG2-cycle window and flags an alarm when the count exceeds a captured threshold.
// Latency: start accepted at edge N -> done visible during the cycle ending at edge N+3+2^WIN_LOG2.
// Backpressure: start is dropped (not queued) while busy or in the done cycle.
// Ports: clk, rst_n (async active-low), start, delayed_clk (async sensor output),
//   thr[CNT_W] -> busy, done (1-cycle pulse), count[CNT_W], alarm.
// Build option: SENSOR_CTRL_CONT_EN makes measurements repeat back-to-back after one start.
module sensor_ctrl
  import sensor_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int CNT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             delayed_clk,
  input  logic [CNT_W-1:0] thr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             alarm
);

  // A full window yields 2^WIN_LOG2 hits, which needs WIN_LOG2+1 bits.
  if (CNT_W < WIN_LOG2 + 1) begin : g_cnt_w_chk
    $error("sensor_ctrl: CNT_W must be at least WIN_LOG2+1");
  end
  if (WIN_LOG2 < 2 || WIN_LOG2 > 16) begin : g_win_chk
    $error("sensor_ctrl: WIN_LOG2 must be in 2..16");
  end

  localparam logic [WIN_LOG2-1:0] FLUSH_LAST = WIN_LOG2'(SYNC_DEPTH - 1);

  state_t               state, state_nxt;
  logic                 sample;
  logic                 arm;
  logic                 last_meas;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic [CNT_W-1:0]     acc;
  logic [CNT_W-1:0]     acc_sum;
  logic [CNT_W-1:0]     thr_q;

  sensor_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (delayed_clk),
    .q     (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FLUSH;
          arm       = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (win_cnt == FLUSH_LAST) state_nxt = ST_MEAS;
      end
      ST_MEAS: begin
        if (&win_cnt) state_nxt = ST_DONE;
      end
      ST_DONE: begin
`ifdef SENSOR_CTRL_CONT_EN
        state_nxt = ST_FLUSH;
        arm       = 1'b1;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_FLUSH) || (state == ST_MEAS);
  assign done      = (state == ST_DONE);
  assign last_meas = (state == ST_MEAS) && (&win_cnt);
  // Include the final window sample so count is valid during the DONE cycle itself.
  assign acc_sum   = acc + CNT_W'(sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      acc     <= '0;
      thr_q   <= '0;
      count   <= '0;
      alarm   <= 1'b0;
    end else begin
      // One counter times both the flush and the window; it restarts on every state change.
      if (state_nxt != state) begin
        win_cnt <= '0;
      end else if (busy) begin
        win_cnt <= win_cnt + WIN_LOG2'(1);
      end

      if (arm) begin
        thr_q <= thr;
        acc   <= '0;
      end else if (state == ST_MEAS) begin
        acc <= acc_sum;
      end

      if (last_meas) begin
        count <= acc_sum;
        alarm <= (acc_sum > thr_q);
      end
    end
  end

endmodule
